ub_access_arbiter: RTL and testbench
====================================

// Module: ub_access_arbiter
// PURPOSE
// - Shares the single-port unified buffer (UB) between N requesters: UART DMA, legacy DMA and the controller.
// - Uses round-robin arbitration with burst locking. Each grant registers one UB access per accepted beat.
// - Routes read data back to the owning requester, tagged by a delayed requester id.
// - Sits between uart_dma_basys3 / legacy DMA / tpu_controller and the tpu_datapath UB port.
// PARAMETERS
// - N_REQ      3    number of requesters (0=UART, 1=DMA, 2=CTRL)
// - ADDR_W     8    UB address width
// - DATA_W     256  UB data width
// - RD_LAT     1    UB read latency, cycles from ub_en to ub_rdata valid (>=1)
// - MAX_BURST  16   beats per grant before forced release
// PORTS
// - clk            in   1               system clock
// - rst            in   1               reset; one clock; reset is asynchronous and active-high
// - req_valid      in   N_REQ           beat request per requester
// - req_ready      out  N_REQ           beat accepted when valid&&ready
// - req_we         in   N_REQ           1=write, 0=read
// - req_last       in   N_REQ           final beat of burst
// - req_addr       in   N_REQ*ADDR_W    packed, requester i at [i*ADDR_W +: ADDR_W]
// - req_wdata      in   N_REQ*DATA_W    packed write data
// - rsp_valid      out  N_REQ           read data valid for requester i
// - rsp_data       out  DATA_W          shared read data bus
// - ub_en          out  1               UB access strobe
// - ub_we          out  1               UB write enable
// - ub_addr        out  ADDR_W          UB address
// - ub_wdata       out  DATA_W          UB write data
// - ub_rdata       in   DATA_W          UB read data
// - grant_id       out  $clog2(N_REQ)   current owner (debug)
// - busy           out  1               state==LOCK or reads in flight
// - burst_err      out  1               sticky: burst exceeded MAX_BURST
// BEHAVIOUR
// - Reset: every output is 0, state=IDLE, rr pointer=0, beat count=0, in-flight read tags are flushed.
//   Reset mid-burst drops pending responses; no rsp_valid is raised after reset.
// - FSM states: IDLE, LOCK.
// - IDLE, any req_valid: pick the first valid at or after the rr pointer (wrapping mod N_REQ).
//   Register grant_id and go to LOCK. req_ready stays all-0 in IDLE, which gives one bubble cycle per grant.
// - LOCK: req_ready[grant_id]=1, all others 0.
// - LOCK, beat accepted: beat count +1.
// - LOCK -> IDLE when either of these holds:
//   - the accepted beat has req_last=1, or
//   - the count reaches MAX_BURST; this also sets burst_err.
//   On the transition, rr pointer <= (grant_id+1) mod N_REQ.
// - LOCK with req_valid deasserted: hold the grant; no timeout.
// - Accepted beat at cycle t: ub_en/ub_we/ub_addr/ub_wdata are registered and driven at t+1.
//   ub_en=0 when no beat is accepted.
// - Read beat: the tag (grant_id) goes through an RD_LAT-deep shift register.
//   rsp_valid[tag]=1 and rsp_data=ub_rdata at cycle t+1+RD_LAT, one cycle wide. Writes produce no response.
// - Responses keep issue order. Back-to-back reads give one response per cycle; requesters must not stall responses.
// - A new grant may overlap in-flight reads of the previous owner; responses stay tagged correctly.
// - Simultaneous last-beat and new requests: the new owner is chosen in the IDLE cycle that follows.
// - Single requester with back-to-back bursts: it is regranted after each bubble (pointer wraps to it).
// - burst_err is cleared only by rst.
// STRUCTURE
// - Package tpu_ub_arb_pkg:
//   - arb_state_e {IDLE, LOCK}
//   - REQ_UART=0, REQ_DMA=1, REQ_CTRL=2
//   - default widths
// - Sub-module rr_pick: combinational round-robin picker (req vector, pointer -> one-hot grant + index, any).
// - Top level holds the FSM, beat counter, UB output registers and the tag shift register.
// TESTING
// - Reset, then UART writes 4 beats addr 0x10..0x13 with last on the 4th.
//   -> ub_en 4 cycles starting 2 cycles after first valid; ub_we=1; addresses match; then IDLE.
// - CTRL reads addr 0x10, RD_LAT=1, UB returns 0xA5..
//   -> rsp_valid[2] 2 cycles after acceptance, rsp_data=0xA5..; rsp_valid[0]/[1] stay 0.
// - All three request continuously with single-beat bursts.
//   -> grant order 0,1,2,0,1,2; one bubble between each grant.
// - DMA streams 20 beats with no last, MAX_BURST=16.
//   -> release after beat 16; burst_err=1; UART/CTRL granted next; DMA rearbitrates later.
// - UART read burst, then an immediate CTRL grant while UART reads are in flight.
//   -> UART responses are tagged 0 and never routed to CTRL.
// - Assert rst mid-burst with 2 reads in flight.
//   -> all outputs 0 immediately; no rsp_valid after deassert; next grant starts from requester 0.

Source files
------------

// File: rtl/tpu_ub_arb_pkg.sv
// Shared types and defaults for the unified-buffer access arbiter.
package tpu_ub_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int REQ_UART = 0;
    localparam int REQ_DMA  = 1;
    localparam int REQ_CTRL = 2;

    localparam int N_REQ_DEF     = 3;
    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 256;
    localparam int RD_LAT_DEF    = 1;
    localparam int MAX_BURST_DEF = 16;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ub_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        int j;
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!any && req[j]) begin
                any        = 1'b1;
                gnt_oh[j]  = 1'b1;
                gnt_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ub_access_arbiter.sv
// Round-robin, burst-locking arbiter in front of the single-port unified buffer,
// with tagged read-response routing back to the issuing requester.
//
// state | meaning
// IDLE  | no owner; pick next requester, no beats accepted (grant bubble)
// LOCK  | owner accepts beats until req_last or MAX_BURST beats
module ub_access_arbiter
    import tpu_ub_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      ub_en,
    output logic                      ub_we,
    output logic [ADDR_W-1:0]         ub_addr,
    output logic [DATA_W-1:0]         ub_wdata,
    input  logic [DATA_W-1:0]         ub_rdata,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      burst_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d, ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nx;
    logic               err_q, err_d;
    logic               ub_en_q, ub_en_d, ub_we_q, ub_we_d;
    logic [ADDR_W-1:0]  ub_addr_q, ub_addr_d;
    logic [DATA_W-1:0]  ub_wdata_q, ub_wdata_d;
    logic               iss_vld_q, iss_vld_d;
    logic [IDX_W-1:0]   iss_tag_q, iss_tag_d;
    logic [RD_LAT-1:0]  rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]   rd_tag_q [RD_LAT];
    logic [IDX_W-1:0]   rd_tag_d [RD_LAT];

    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               sel_valid, sel_we, sel_last, accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_we    = 1'b0;
        sel_last  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_we    = req_we[i];
                sel_last  = req_last[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept = (state_q == LOCK) && sel_valid;
    assign cnt_nx = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ub_en_d    = 1'b0;
        ub_we_d    = 1'b0;
        ub_addr_d  = '0;
        ub_wdata_d = '0;
        iss_vld_d  = 1'b0;
        iss_tag_d  = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = LOCK;
                    grant_d    = pick_idx;
                    grant_oh_d = pick_oh;
                    cnt_d      = '0;
                end
            end
            LOCK: begin
                if (accept) begin
                    ub_en_d    = 1'b1;
                    ub_we_d    = sel_we;
                    ub_addr_d  = sel_addr;
                    ub_wdata_d = sel_we ? sel_wdata : '0;
                    iss_vld_d  = !sel_we;
                    cnt_d      = cnt_nx;
                    if (sel_last || cnt_nx == CNT_W'(MAX_BURST)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        ptr_d   = IDX_W'(wrap_inc(int'(grant_q), N_REQ));
                        // a full-length burst that still carries no last beat overran its window
                        if (!sel_last) err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_vld_d = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            if (k == 0) begin
                rd_vld_d[k] = iss_vld_q;
                rd_tag_d[k] = iss_tag_q;
            end else begin
                rd_vld_d[k] = rd_vld_q[k-1];
                rd_tag_d[k] = rd_tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ub_en_q    <= 1'b0;
            ub_we_q    <= 1'b0;
            ub_addr_q  <= '0;
            ub_wdata_q <= '0;
            iss_vld_q  <= 1'b0;
            iss_tag_q  <= '0;
            rd_vld_q   <= '0;
            for (int k = 0; k < RD_LAT; k++) rd_tag_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ub_en_q    <= ub_en_d;
            ub_we_q    <= ub_we_d;
            ub_addr_q  <= ub_addr_d;
            ub_wdata_q <= ub_wdata_d;
            iss_vld_q  <= iss_vld_d;
            iss_tag_q  <= iss_tag_d;
            rd_vld_q   <= rd_vld_d;
            for (int k = 0; k < RD_LAT; k++) rd_tag_q[k] <= rd_tag_d[k];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = rd_vld_q[RD_LAT-1] && (rd_tag_q[RD_LAT-1] == IDX_W'(i));
        end
    end

    // gate the shared bus so it reads 0 whenever nothing is being returned
    assign rsp_data  = rd_vld_q[RD_LAT-1] ? ub_rdata : '0;
    assign req_ready = (state_q == LOCK) ? grant_oh_q : '0;
    assign ub_en     = ub_en_q;
    assign ub_we     = ub_we_q;
    assign ub_addr   = ub_addr_q;
    assign ub_wdata  = ub_wdata_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == LOCK) || iss_vld_q || (|rd_vld_q);
    assign burst_err = err_q;

endmodule

// File: tb/tb_ub_access_arbiter.sv
// Directed bench for ub_access_arbiter with a behavioural UB read model.
module tb_ub_access_arbiter;
    import tpu_ub_arb_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid, req_ready, req_we, req_last, rsp_valid;
    logic [23:0]   req_addr;
    logic [767:0]  req_wdata;
    logic [255:0]  rsp_data, ub_wdata, ub_rdata;
    logic          ub_en, ub_we, busy, burst_err;
    logic [7:0]    ub_addr;
    logic [1:0]    grant_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ub_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ub_en(ub_en), .ub_we(ub_we), .ub_addr(ub_addr), .ub_wdata(ub_wdata),
        .ub_rdata(ub_rdata), .grant_id(grant_id), .busy(busy), .burst_err(burst_err)
    );

    function automatic logic [255:0] rd_word(input logic [7:0] a);
        return {32{a ^ 8'hB5}};
    endfunction

    // UB with one cycle read latency; contents are a fixed function of address
    initial ub_rdata = '0;
    always @(posedge clk) if (ub_en && !ub_we) ub_rdata <= rd_word(ub_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [7:0] a);
        req_addr[r*8 +: 8]       = a;
        req_wdata[r*256 +: 256]  = {32{a}};
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 256'(req_ready), 256'(0));
        chk({tag, "_rspv"},  256'(rsp_valid), 256'(0));
        chk({tag, "_rspd"},  rsp_data, 256'(0));
        chk({tag, "_en"},    256'(ub_en), 256'(0));
        chk({tag, "_we"},    256'(ub_we), 256'(0));
        chk({tag, "_addr"},  256'(ub_addr), 256'(0));
        chk({tag, "_wdata"}, ub_wdata, 256'(0));
        chk({tag, "_gid"},   256'(grant_id), 256'(0));
        chk({tag, "_busy"},  256'(busy), 256'(0));
        chk({tag, "_err"},   256'(burst_err), 256'(0));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;

        // UART writes 0x10..0x13
        req_valid = 3'b001; req_we = 3'b001; req_last = 3'b000;
        set_req(REQ_UART, 8'h10);
        step();
        chk("w_ready", 256'(req_ready), 256'(3'b001));
        chk("w_gid",   256'(grant_id), 256'(0));
        chk("w_bub_en", 256'(ub_en), 256'(0));
        for (int b = 0; b < 4; b++) begin
            set_req(REQ_UART, 8'(8'h10 + b));
            req_last = (b == 3) ? 3'b001 : 3'b000;
            step();
            chk("w_en",   256'(ub_en), 256'(1));
            chk("w_we",   256'(ub_we), 256'(1));
            chk("w_addr", 256'(ub_addr), 256'(8'h10 + b));
        end
        chk("w_wdata",   ub_wdata, {32{8'h13}});
        chk("w_idle",    256'(req_ready), 256'(0));
        chk("w_busy",    256'(busy), 256'(0));
        req_valid = '0; req_last = '0;
        step();
        chk("w_en_off", 256'(ub_en), 256'(0));

        // CTRL single read
        req_valid = 3'b100; req_we = 3'b000; req_last = 3'b100;
        set_req(REQ_CTRL, 8'h10);
        step();
        chk("r_gid",   256'(grant_id), 256'(2));
        chk("r_ready", 256'(req_ready), 256'(3'b100));
        step();
        req_valid = '0;
        chk("r_en",    256'(ub_en), 256'(1));
        chk("r_we",    256'(ub_we), 256'(0));
        chk("r_addr",  256'(ub_addr), 256'(8'h10));
        chk("r_rsp_early", 256'(rsp_valid), 256'(0));
        step();
        chk("r_rspv",  256'(rsp_valid), 256'(3'b100));
        chk("r_rspd",  rsp_data, {32{8'hA5}});
        chk("r_busy",  256'(busy), 256'(1));
        step();
        chk("r_rsp_off", 256'(rsp_valid), 256'(0));
        chk("r_busy_off", 256'(busy), 256'(0));

        // round robin with single-beat writes from everyone
        req_valid = 3'b111; req_we = 3'b111; req_last = 3'b111;
        set_req(REQ_UART, 8'h01); set_req(REQ_DMA, 8'h02); set_req(REQ_CTRL, 8'h03);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_gid",   256'(grant_id), 256'(k % 3));
            chk("rr_ready", 256'(req_ready), 256'(3'b001 << (k % 3)));
            step();
            chk("rr_bubble", 256'(req_ready), 256'(0));
            chk("rr_addr",   256'(ub_addr), 256'((k % 3) + 1));
        end
        req_valid = '0;

        // DMA overruns MAX_BURST
        req_valid = 3'b010; req_we = 3'b111; req_last = 3'b000;
        set_req(REQ_DMA, 8'h50);
        step();
        chk("ob_gid", 256'(grant_id), 256'(1));
        req_valid = 3'b111; req_last = 3'b101;
        for (int b = 1; b <= 16; b++) begin
            step();
            chk("ob_en", 256'(ub_en), 256'(1));
            if (b == 15) begin
                chk("ob_ready15", 256'(req_ready), 256'(3'b010));
                chk("ob_err15",   256'(burst_err), 256'(0));
            end
        end
        chk("ob_release", 256'(req_ready), 256'(0));
        chk("ob_err",     256'(burst_err), 256'(1));
        step();
        chk("ob_next_gid", 256'(grant_id), 256'(2));
        chk("ob_bub_en",   256'(ub_en), 256'(0));
        step();
        chk("ob_ctrl_addr", 256'(ub_addr), 256'(8'h03));
        req_valid = 3'b011;
        step();
        chk("ob_uart_gid", 256'(grant_id), 256'(0));
        step();
        chk("ob_uart_addr", 256'(ub_addr), 256'(8'h01));
        req_valid = 3'b010;
        step();
        chk("ob_dma_again", 256'(grant_id), 256'(1));
        req_last = 3'b010;
        step();
        chk("ob_dma_done", 256'(req_ready), 256'(0));
        chk("ob_err_sticky", 256'(burst_err), 256'(1));
        req_valid = '0; req_last = '0;

        // UART reads in flight while CTRL takes the grant
        req_valid = 3'b001; req_we = 3'b000; req_last = 3'b000;
        set_req(REQ_UART, 8'h20);
        step();
        chk("ov_gid0", 256'(grant_id), 256'(0));
        req_valid = 3'b101; req_last = 3'b100;
        set_req(REQ_CTRL, 8'h30);
        step();
        chk("ov_addr20", 256'(ub_addr), 256'(8'h20));
        set_req(REQ_UART, 8'h21); req_last = 3'b101;
        step();
        chk("ov_rspv0", 256'(rsp_valid), 256'(3'b001));
        chk("ov_rspd0", rsp_data, rd_word(8'h20));
        req_valid = 3'b100;
        step();
        chk("ov_rspv1", 256'(rsp_valid), 256'(3'b001));
        chk("ov_rspd1", rsp_data, rd_word(8'h21));
        chk("ov_gid2",  256'(grant_id), 256'(2));
        step();
        chk("ov_gap",   256'(rsp_valid), 256'(0));
        chk("ov_addr30", 256'(ub_addr), 256'(8'h30));
        req_valid = '0; req_last = '0;
        step();
        chk("ov_rspv2", 256'(rsp_valid), 256'(3'b100));
        chk("ov_rspd2", rsp_data, rd_word(8'h30));

        // reset mid-burst with reads in flight; pointer is 1 beforehand
        req_valid = 3'b001; req_we = 3'b001; req_last = 3'b001;
        set_req(REQ_UART, 8'h60);
        step(); step();
        req_valid = 3'b010; req_we = 3'b000; req_last = 3'b000;
        set_req(REQ_DMA, 8'h40);
        step();
        chk("mr_gid", 256'(grant_id), 256'(1));
        step();
        set_req(REQ_DMA, 8'h41);
        step();
        chk("mr_rspv", 256'(rsp_valid), 256'(3'b010));
        chk("mr_busy", 256'(busy), 256'(1));
        #1 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        req_valid = '0;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post_rspv", 256'(rsp_valid), 256'(0));
            chk("post_en",   256'(ub_en), 256'(0));
        end
        req_valid = 3'b111; req_we = 3'b111; req_last = 3'b111;
        step();
        chk("post_gid",   256'(grant_id), 256'(0));
        chk("post_ready", 256'(req_ready), 256'(3'b001));
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
